fpu_divider: RTL

FPU_DIVIDER -- requirements
Module: fpu_divider

---
 rtl/fpu_pkg.sv | 31 +++
 rtl/fpu_divider_if.sv | 30 +++
 rtl/fpu_classify.sv | 30 +++
 rtl/fpu_divider.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// ============================================================================
// Module      : fpu_pkg
// Description : Shared binary32 constants, state encoding and float struct.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package fpu_pkg;

   localparam logic [31:0] QNAN      = 32'h7FC0_0000;
   localparam logic [31:0] QNAN_NEG  = 32'hFFC0_0000;
   localparam int          BIAS      = 127;
   localparam int          EXP_MAX   = 255;
   localparam int          DIV_ITERS = 26;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_DIVIDE = 2'd1,
      S_ROUND  = 2'd2,
      S_DONE   = 2'd3
   } fpu_state_e;

   typedef struct packed {
      logic        sign;
      logic [7:0]  exp;
      logic [22:0] frac;
   } fpu_float_t;

endpackage

`default_nettype wire

// File: rtl/fpu_divider_if.sv
// ============================================================================
// Module      : fpu_divider_if
// Description : Operand/result valid-ready handshake bundle for the divider.
// Revision    : 1.0
// ============================================================================
`default_nettype none

interface fpu_divider_if;

   logic        in_valid;
   logic        in_ready;
   logic [31:0] a;
   logic [31:0] b;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] op;

   modport master (
      output in_valid, a, b, out_ready,
      input  in_ready, out_valid, op
   );

   modport slave (
      input  in_valid, a, b, out_ready,
      output in_ready, out_valid, op
   );

endinterface

`default_nettype wire

// File: rtl/fpu_classify.sv
// ============================================================================
// Module      : fpu_classify
// Description : Combinational NaN / infinity / zero flags for one operand.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module fpu_classify
   import fpu_pkg::*;
(
   input  fpu_float_t float_i,
   output logic       is_nan_o,
   output logic       is_inf_o,
   output logic       is_zero_o
);

   logic w_exp_max;
   logic w_frac_nz;

   assign w_exp_max = (float_i.exp == 8'hFF);
   assign w_frac_nz = |float_i.frac;

   assign is_nan_o  = w_exp_max &  w_frac_nz;
   assign is_inf_o  = w_exp_max & ~w_frac_nz;
   // Subnormals fold into zero: the datapath has no denormal support.
   assign is_zero_o = (float_i.exp == 8'h00);

endmodule

`default_nettype wire

// File: rtl/fpu_divider.sv
// ============================================================================
// Module      : fpu_divider
// Description : Multi-cycle binary32 divider, restoring division + RNE round.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module fpu_divider
   import fpu_pkg::*;
(
   input  logic          clk,
   input  logic          rst,
   fpu_divider_if.slave  bus
);

   localparam logic [4:0]        c_last_iter = 5'(DIV_ITERS - 1);
   localparam logic signed [9:0] c_exp_max   = 10'(EXP_MAX);

   fpu_state_e         state_q, state_d;
   logic [4:0]         cnt_q,   cnt_d;
   logic [25:0]        quo_q,   quo_d;
   logic [24:0]        rem_q,   rem_d;
   logic [23:0]        div_q,   div_d;
   logic signed [9:0]  exp_q,   exp_d;
   logic               sign_q,  sign_d;
   logic [31:0]        op_q,    op_d;

   fpu_float_t w_fa;
   fpu_float_t w_fb;
   logic       w_nan_a, w_inf_a, w_zero_a;
   logic       w_nan_b, w_inf_b, w_zero_b;
   logic       w_sign;
   logic       w_special;
   logic [31:0] w_special_op;

   assign w_fa   = bus.a;
   assign w_fb   = bus.b;
   assign w_sign = w_fa.sign ^ w_fb.sign;

   fpu_classify u_cls_a (
      .float_i   (w_fa),
      .is_nan_o  (w_nan_a),
      .is_inf_o  (w_inf_a),
      .is_zero_o (w_zero_a)
   );

   fpu_classify u_cls_b (
      .float_i   (w_fb),
      .is_nan_o  (w_nan_b),
      .is_inf_o  (w_inf_b),
      .is_zero_o (w_zero_b)
   );

   assign w_special = w_nan_a | w_nan_b | w_inf_a | w_inf_b | w_zero_a | w_zero_b;

   always_comb begin
      w_special_op = {w_sign, 31'd0};
      if (w_nan_a | w_nan_b)
         w_special_op = QNAN;
      else if ((w_inf_a & w_inf_b) | (w_zero_a & w_zero_b))
         w_special_op = QNAN_NEG;
      else if (w_inf_a | w_zero_b)
         w_special_op = {w_sign, 8'hFF, 23'd0};
   end

   // One restoring step: subtract when the partial remainder covers the divisor.
   logic        w_ge;
   logic [24:0] w_diff;
   logic [24:0] w_rem_sel;

   assign w_ge      = (rem_q >= {1'b0, div_q});
   assign w_diff    = rem_q - {1'b0, div_q};
   assign w_rem_sel = w_ge ? w_diff : rem_q;

   // Normalise, round to nearest even, then clamp the exponent range.
   logic              w_q25;
   logic [23:0]       w_mant;
   logic              w_guard;
   logic              w_sticky;
   logic              w_rup;
   logic [24:0]       w_mant_r;
   logic [22:0]       w_frac;
   logic signed [9:0] w_exp_n;
   logic signed [9:0] w_exp_f;
   logic [31:0]       w_round_op;

   assign w_q25    = quo_q[25];
   assign w_mant   = w_q25 ? quo_q[25:2] : quo_q[24:1];
   assign w_guard  = w_q25 ? quo_q[1]    : quo_q[0];
   assign w_sticky = (w_q25 & quo_q[0]) | (|rem_q);
   assign w_rup    = w_guard & (w_sticky | w_mant[0]);
   assign w_mant_r = {1'b0, w_mant} + {24'd0, w_rup};
   assign w_frac   = w_mant_r[24] ? w_mant_r[23:1] : w_mant_r[22:0];
   assign w_exp_n  = exp_q - (w_q25 ? 10'sd0 : 10'sd1);
   assign w_exp_f  = w_exp_n + (w_mant_r[24] ? 10'sd1 : 10'sd0);

   always_comb begin
      if (w_exp_f >= c_exp_max)
         w_round_op = {sign_q, 8'hFF, 23'd0};
      else if (w_exp_f <= 10'sd0)
         w_round_op = {sign_q, 31'd0};
      else
         w_round_op = {sign_q, w_exp_f[7:0], w_frac};
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      quo_d   = quo_q;
      rem_d   = rem_q;
      div_d   = div_q;
      exp_d   = exp_q;
      sign_d  = sign_q;
      op_d    = op_q;
      case (state_q)
         S_IDLE: begin
            if (bus.in_valid) begin
               sign_d = w_sign;
               if (w_special) begin
                  op_d    = w_special_op;
                  state_d = S_DONE;
               end else begin
                  rem_d   = {2'b01, w_fa.frac};
                  div_d   = {1'b1, w_fb.frac};
                  quo_d   = 26'd0;
                  cnt_d   = 5'd0;
                  exp_d   = {2'b00, w_fa.exp} - {2'b00, w_fb.exp} + 10'(BIAS);
                  state_d = S_DIVIDE;
               end
            end
         end
         S_DIVIDE: begin
            quo_d = {quo_q[24:0], w_ge};
            rem_d = w_rem_sel << 1;
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == c_last_iter)
               state_d = S_ROUND;
         end
         S_ROUND: begin
            op_d    = w_round_op;
            state_d = S_DONE;
         end
         S_DONE: begin
            if (bus.out_ready)
               state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= 5'd0;
         quo_q   <= 26'd0;
         rem_q   <= 25'd0;
         div_q   <= 24'd0;
         exp_q   <= 10'sd0;
         sign_q  <= 1'b0;
         op_q    <= 32'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         quo_q   <= quo_d;
         rem_q   <= rem_d;
         div_q   <= div_d;
         exp_q   <= exp_d;
         sign_q  <= sign_d;
         op_q    <= op_d;
      end
   end

   assign bus.in_ready  = (state_q == S_IDLE);
   assign bus.out_valid = (state_q == S_DONE);
   assign bus.op        = op_q;

endmodule

`default_nettype wire
